// File: rtl/efp_lut_search_arbiter.sv
// efp_lut_search_arbiter
// Shared BCD-to-EFP8 conversion engine. Requesters are served round-robin;
// each accepted word is converted by a 7-probe binary search over an external
// 128-entry threshold ROM with a one-cycle read latency. The result
// {sign, idx} is returned over a valid/ready output.
module efp_lut_search_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rom_en,
    output logic [6:0]           rom_addr,
    input  logic [31:0]          rom_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_code,
    output logic [ID_W-1:0]      out_id,
    output logic                 out_sat,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last;      // most recently granted requester
    logic [27:0]     mag;       // packed-BCD magnitude of the job in flight
    logic            sign;
    logic [ID_W-1:0] id;
    logic [6:0]      idx;       // search result built MSB first
    logic [2:0]      bit_pos;   // bit of idx decided by the current probe

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [31:0]     sel_word;
    logic [6:0]      probe_mask;
    logic [6:0]      idx_next;
    logic            unused_hi;

    // Round-robin pick: first valid requester after the last one served.
    always_comb begin
        int cand;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last) + off) % N_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Word of the granted requester; bits 31:29 carry no meaning.
    always_comb begin
        int sel_base;
        sel_base  = 32 * int'(grant_idx);
        sel_word  = req_data[sel_base +: 32];
        unused_hi = ^sel_word[31:29];
    end

    // Accept strobe: only in IDLE, never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Outcome of the current comparison against the threshold just read.
    always_comb begin
        probe_mask = 7'd1 << bit_pos;
        idx_next   = ({4'b0000, mag} >= rom_data) ? (idx | probe_mask) : idx;
    end

    // Busy whenever a job is held anywhere in the pipeline.
    always_comb begin
        busy = (state != IDLE);
    end

    // Search FSM with registered ROM and result outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            last      <= ID_W'(N_REQ - 1);
            mag       <= '0;
            sign      <= 1'b0;
            id        <= '0;
            idx       <= '0;
            bit_pos   <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_id    <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        mag      <= sel_word[27:0];
                        sign     <= sel_word[28];
                        id       <= grant_idx;
                        last     <= grant_idx;
                        idx      <= '0;
                        bit_pos  <= 3'd6;
                        rom_en   <= 1'b1;
                        rom_addr <= 7'h40;
                        state    <= PROBE;
                    end
                end
                PROBE: begin
                    rom_en <= 1'b0;
                    state  <= CMP;
                end
                CMP: begin
                    idx <= idx_next;
                    if (bit_pos == 3'd0) begin
                        out_valid <= 1'b1;
                        out_id    <= id;
                        out_sat   <= (idx_next == 7'h7F);
                        out_code  <= (idx_next == 7'h00) ? 8'h00 : {sign, idx_next};
                        state     <= DONE;
                    end else begin
                        bit_pos  <= bit_pos - 3'd1;
                        rom_en   <= 1'b1;
                        rom_addr <= idx_next | (probe_mask >> 1);
                        state    <= PROBE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_efp_lut_search_arbiter.sv
// Testbench for efp_lut_search_arbiter: directed scenarios plus randomized
// jobs, checked against a decimal-domain reference model of the threshold
// lookup and the round-robin rule.
module tb_efp_lut_search_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                rom_en;
    logic [6:0]          rom_addr;
    logic [31:0]         rom_data;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_code;
    logic [ID_W-1:0]     out_id;
    logic                out_sat;
    logic                busy;

    logic [31:0] words [N_REQ];
    logic [31:0] rom [128];
    logic [31:0] rom_q = '0;
    int          rom_cnt = 0;

    int n_assert = 0;
    int n_fail   = 0;
    int model_last = N_REQ - 1;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N_REQ; k++) begin : g_pack
        assign req_data[32*k +: 32] = words[k];
    end

    // External single-port ROM, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom[rom_addr];
    end
    assign rom_data = rom_q;

    // Count ROM reads.
    always @(posedge clk) begin
        if (rom_en) rom_cnt <= rom_cnt + 1;
    end

    efp_lut_search_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_id    (out_id),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic int thr_dec(input int i);
        return 51 + (i * i * 116) / 100;
    endfunction

    function automatic logic [31:0] dec_to_bcd(input int v);
        logic [31:0] b;
        int          r;
        b = '0;
        r = v;
        for (int d = 0; d < 8; d++) begin
            b[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic int bcd_to_dec(input logic [27:0] b);
        int v;
        v = 0;
        for (int d = 6; d >= 0; d--) v = v * 10 + int'(b[4*d +: 4]);
        return v;
    endfunction

    function automatic int model_idx(input logic [31:0] w);
        int m;
        int r;
        m = bcd_to_dec(w[27:0]);
        r = 0;
        for (int i = 1; i < 128; i++) if (m >= thr_dec(i)) r = i;
        return r;
    endfunction

    function automatic int model_grant(input logic [N_REQ-1:0] mask, input int lst);
        for (int off = 1; off <= N_REQ; off++) begin
            if (mask[(lst + off) % N_REQ]) return (lst + off) % N_REQ;
        end
        return -1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Serve one job: wait for a grant, check it against the model, follow the
    // search to completion, hold the result for `hold` cycles, then release.
    task automatic transact(input int hold, input bit drop, output int g);
        int          n;
        int          exp_g;
        int          lat;
        int          rc0;
        int          e_idx;
        logic [31:0] w;
        logic [7:0]  e_code;
        logic        e_sat;
        g = -1;
        settle();
        n = 0;
        while (req_ready == '0 && n < 64) begin
            tick();
            settle();
            n++;
        end
        exp_g = model_grant(req_valid, model_last);
        check("grant_onehot", req_ready, (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
        if (req_ready == '0 || exp_g < 0) return;
        for (int k = 0; k < N_REQ; k++) if (req_ready[k]) g = k;
        w          = words[exp_g];
        model_last = exp_g;
        e_idx      = model_idx(w);
        e_code     = (e_idx == 0) ? 8'h00 : {w[28], 7'(e_idx)};
        e_sat      = (e_idx == 127);
        rc0        = rom_cnt;
        tick();
        if (drop) req_valid[exp_g] = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, 15);
        check("rom_reads", rom_cnt - rc0, 7);
        check("out_code", out_code, e_code);
        check("out_id", out_id, exp_g);
        check("out_sat", out_sat, e_sat);
        check("busy_done", busy, 1);
        for (int h = 0; h < hold; h++) begin
            tick();
            settle();
            check("hold_valid", out_valid, 1);
            check("hold_code", out_code, e_code);
            check("hold_id", out_id, exp_g);
            check("hold_sat", out_sat, e_sat);
            check("hold_ready0", req_ready, 0);
            check("hold_rom_en0", rom_en, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid0", out_valid, 0);
        check("release_idle", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_last = N_REQ - 1;
    endtask

    // Watchdog: the main sequence must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          g;
        int          val;
        logic [31:0] w;
        for (int i = 0; i < 128; i++) rom[i] = dec_to_bcd(thr_dec(i));
        for (int k = 0; k < N_REQ; k++) words[k] = '0;
        req_valid = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        model_last = N_REQ - 1;

        // Directed conversions with fixed expected codes.
        words[0] = 32'h0000_1250; req_valid = 4'b0001;
        transact(0, 1, g);
        check("dir_1250_code", out_code, 8'h20);
        words[1] = 32'h1000_1300; req_valid = 4'b0010;
        transact(0, 1, g);
        check("dir_1300_id", g, 1);
        words[2] = 32'h1000_0000; req_valid = 4'b0100;
        transact(0, 1, g);
        words[3] = 32'h0000_0050; req_valid = 4'b1000;
        transact(0, 1, g);
        words[0] = 32'h0500_0000; req_valid = 4'b0001;
        transact(0, 1, g);
        words[0] = 32'hE469_5061; req_valid = 4'b0001;
        transact(0, 1, g);
        check("model_sat_hi_bits", model_idx(words[0]), 127);

        // Round robin with all requesters valid: 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < N_REQ; k++) words[k] = dec_to_bcd(1000 * (k + 1));
        req_valid = 4'b1111;
        transact(0, 0, g); check("rr_0", g, 0);
        transact(0, 0, g); check("rr_1", g, 1);
        transact(0, 0, g); check("rr_2", g, 2);
        transact(0, 0, g); check("rr_3", g, 3);
        transact(0, 0, g); check("rr_4", g, 0);
        req_valid = 4'b1010;
        transact(0, 0, g); check("rr_only13_a", g, 1);
        transact(0, 0, g); check("rr_only13_b", g, 3);
        req_valid = '0;

        // Backpressure in DONE, then an immediate regrant.
        words[2] = dec_to_bcd(777);
        req_valid = 4'b0100;
        transact(5, 0, g);
        check("bp_regrant", req_ready, 4'b0100);
        transact(0, 1, g);
        check("bp_second_id", g, 2);

        // Reset during the CMP cycle of the third probe.
        words[0] = dec_to_bcd(5000);
        req_valid = 4'b0001;
        settle();
        check("mid_rst_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (5) tick();
        check("mid_rst_pre_busy", busy, 1);
        check("mid_rst_pre_rom_en", rom_en, 0);
        rst = 1'b1;
        settle();
        check("mid_rst_ready_gated", req_ready, 0);
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_rom_en", rom_en, 0);
        rst = 1'b0;
        model_last = N_REQ - 1;
        words[2] = dec_to_bcd(3000);
        req_valid = 4'b0101;
        transact(0, 1, g);
        check("post_rst_first", g, 0);
        transact(0, 1, g);
        check("post_rst_second", g, 2);
        req_valid = '0;

        // Randomized jobs with random contention.
        for (int j = 0; j < 24; j++) begin
            for (int k = 0; k < N_REQ; k++) begin
                val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9999999))
                                                  : int'($urandom_range(0, 20000));
                w = dec_to_bcd(val);
                w[28] = 1'($urandom);
                w[31:29] = 3'($urandom);
                words[k] = w;
            end
            req_valid = 4'($urandom_range(1, 15));
            transact(int'($urandom_range(0, 2)), 1, g);
            req_valid = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
